// File: rtl/y86_pkg.sv
// y86_pkg -- shared definitions for the Y86-64 sequential controller.
//   Instruction codes, status codes, controller state enum and small
//   icode classification helpers.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_HALT
  } state_e;

  // Instructions that touch data memory and therefore wait for mem_ready.
  function automatic logic is_mem_icode(input logic [3:0] ic);
    return (ic == I_RMMOVQ) || (ic == I_MRMOVQ) || (ic == I_CALL) ||
           (ic == I_RET)    || (ic == I_PUSHQ)  || (ic == I_POPQ);
  endfunction

  function automatic logic is_valid_icode(input logic [3:0] ic);
    return ic <= I_POPQ;
  endfunction

endpackage

// File: rtl/y86_pc_sel.sv
// y86_pc_sel -- combinational next-PC selection.
//   icode  : instruction code of the retiring instruction
//   cond   : branch condition from execute
//   valC   : constant word (jump/call target)
//   valM   : word read from memory (return address)
//   valP   : address of the sequentially next instruction
//   pc_next: selected next PC
module y86_pc_sel
  import y86_pkg::*;
(
  input  logic [3:0]  icode,
  input  logic        cond,
  input  logic [63:0] valC,
  input  logic [63:0] valM,
  input  logic [63:0] valP,
  output logic [63:0] pc_next
);

  always_comb begin
    pc_next = valP;
    if (icode == I_CALL || (icode == I_JXX && cond)) begin
      pc_next = valC;
    end else if (icode == I_RET) begin
      pc_next = valM;
    end
  end

endmodule

// File: rtl/y86_seq_ctrl.sv
// y86_seq_ctrl -- sequencing FSM for a non-pipelined Y86-64 core.
//   Steps one instruction at a time through fetch/decode/execute/memory/
//   writeback/PC-update, raising one stage strobe per stage, and stops in
//   HALT on halt, illegal instruction or memory fault.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     leave IDLE and begin fetching at PC
//   icode, ifun               decoded fields from fetch
//   cond                      branch condition from execute
//   instruct_err, mem_err     fault flags from fetch / memory
//   valC, valP, valM          next-PC candidates
//   mem_ready                 data-memory completion handshake
//   PC                        current instruction address
//   f_en..w_en                one-hot stage strobes
//   cc_we                     condition-code write enable (OPq in EXECUTE)
//   stat                      AOK=1 HLT=2 ADR=3 INS=4
//   busy, halted              activity / halt indicators
// Build option: define PERF_CNT_EN to add cycle_cnt and inst_cnt outputs.
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | waiting for start
// FETCH     | f_en; classify faults / halt
// DECODE    | d_en
// EXECUTE   | e_en; cc_we for OPq; arm memory timeout
// MEMORY    | m_en; held for memory ops until mem_ready or timeout
// WRITEBACK | w_en
// PCUPD     | load next PC
// HALT      | stopped until rst; PC and stat frozen
module y86_seq_ctrl
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'd0,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic        cond,
  input  logic        instruct_err,
  input  logic        mem_err,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic [63:0] valM,
  input  logic        mem_ready,
  output logic [63:0] PC,
  output logic        f_en,
  output logic        d_en,
  output logic        e_en,
  output logic        m_en,
  output logic        w_en,
  output logic        cc_we,
  output logic [2:0]  stat,
`ifdef PERF_CNT_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] inst_cnt,
`endif
  output logic        busy,
  output logic        halted
);

  localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  // Down-counter starts at MEM_TIMEOUT-1 so that the MEM_TIMEOUT-th
  // consecutive cycle without mem_ready is the one that faults.
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [63:0]       pc_q, pc_d;
  logic [2:0]        stat_q, stat_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [63:0]       pc_next;

  // Function code is consumed by execute, not by sequencing.
  logic unused_ifun;
  assign unused_ifun = ^ifun;

  y86_pc_sel u_pc_sel (
    .icode   (icode),
    .cond    (cond),
    .valC    (valC),
    .valM    (valM),
    .valP    (valP),
    .pc_next (pc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      stat_q  <= STAT_AOK;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stat_d  = stat_q;
    tmo_d   = tmo_q;
    f_en    = 1'b0;
    d_en    = 1'b0;
    e_en    = 1'b0;
    m_en    = 1'b0;
    w_en    = 1'b0;
    cc_we   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        f_en = 1'b1;
        if (mem_err) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else if (instruct_err || !is_valid_icode(icode)) begin
          stat_d  = STAT_INS;
          state_d = S_HALT;
        end else if (icode == I_HALT) begin
          stat_d  = STAT_HLT;
          state_d = S_HALT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        d_en    = 1'b1;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        e_en    = 1'b1;
        cc_we   = (icode == I_OPQ);
        tmo_d   = TMO_LOAD;
        state_d = S_MEMORY;
      end
      S_MEMORY: begin
        m_en = 1'b1;
        if (mem_err) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else if (!is_mem_icode(icode) || mem_ready) begin
          state_d = S_WRITEBACK;
        end else if (tmo_q == '0) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      S_WRITEBACK: begin
        w_en    = 1'b1;
        state_d = S_PCUPD;
      end
      S_PCUPD: begin
        pc_d    = pc_next;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign PC     = pc_q;
  assign stat   = stat_q;
  assign busy   = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted = (state_q == S_HALT);

`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt_q, inst_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      inst_cnt_q  <= '0;
    end else begin
      if (busy) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (state_q == S_PCUPD) inst_cnt_q <= inst_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign inst_cnt  = inst_cnt_q;
`endif

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// tb_y86_seq_ctrl -- self-checking bench for y86_seq_ctrl.
//   Directed scenarios plus a randomized instruction stream compared with
//   a behavioural model that predicts the per-cycle stage trace, the next
//   PC and the final status of each instruction.
module tb_y86_seq_ctrl;

  localparam logic [63:0] RST_PC = 64'h1000;
  localparam int          MEM_TO = 6;

  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] HLT = 3'd2;
  localparam logic [2:0] ADR = 3'd3;
  localparam logic [2:0] INS = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  icode = 4'h0;
  logic [3:0]  ifun = 4'h0;
  logic        cond = 1'b0;
  logic        instruct_err = 1'b0;
  logic        mem_err = 1'b0;
  logic [63:0] valC = '0, valP = '0, valM = '0;
  logic        mem_ready = 1'b0;
  logic [63:0] PC;
  logic        f_en, d_en, e_en, m_en, w_en, cc_we;
  logic [2:0]  stat;
  logic        busy, halted;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, inst_cnt;
`endif

  int checks = 0;
  int errors = 0;

  y86_seq_ctrl #(.RESET_PC(RST_PC), .MEM_TIMEOUT(MEM_TO)) dut (
    .clk(clk), .rst(rst), .start(start), .icode(icode), .ifun(ifun),
    .cond(cond), .instruct_err(instruct_err), .mem_err(mem_err),
    .valC(valC), .valP(valP), .valM(valM), .mem_ready(mem_ready),
    .PC(PC), .f_en(f_en), .d_en(d_en), .e_en(e_en), .m_en(m_en),
    .w_en(w_en), .cc_we(cc_we), .stat(stat),
`ifdef PERF_CNT_EN
    .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt),
`endif
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  function automatic bit m_is_mem(input logic [3:0] ic);
    return (ic == 4'h4) || (ic == 4'h5) || (ic >= 4'h8 && ic <= 4'hB);
  endfunction

  // Expected trace: one char per cycle from FETCH entry; f/d/e/m/w for the
  // stage strobe, E for execute with cc_we, '-' for PC update, H for halt.
  function automatic string m_trace(input logic [3:0] ic, input int waits,
                                    input int ferr, input bit merr);
    string s;
    s = "f";
    if (ferr != 0 || ic == 4'h0 || ic > 4'hB) return {s, "H"};
    s = {s, "d", (ic == 4'h6) ? "E" : "e"};
    if (merr) return {s, "mH"};
    if (m_is_mem(ic)) begin
      if (waits >= MEM_TO) begin
        for (int i = 0; i < MEM_TO; i++) s = {s, "m"};
        return {s, "H"};
      end
      for (int i = 0; i <= waits; i++) s = {s, "m"};
    end else begin
      s = {s, "m"};
    end
    return {s, "w-"};
  endfunction

  function automatic logic [2:0] m_stat(input logic [3:0] ic, input int waits,
                                        input int ferr, input bit merr);
    if (ferr == 2) return ADR;
    if (ferr == 1 || ic > 4'hB) return INS;
    if (ic == 4'h0) return HLT;
    if (merr) return ADR;
    if (m_is_mem(ic) && waits >= MEM_TO) return ADR;
    return AOK;
  endfunction

  function automatic logic [63:0] m_next_pc(input logic [3:0] ic, input logic cnd,
      input logic [63:0] vc, input logic [63:0] vp, input logic [63:0] vm);
    if (ic == 4'h8 || (ic == 4'h7 && cnd)) return vc;
    if (ic == 4'h9) return vm;
    return vp;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'($urandom_range(0, 1));
    step();
    rst = 1'b0;
    start = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Runs one instruction from a FETCH sample point; returns the observed
  // trace and leaves the bench at the next FETCH (or in HALT).
  task automatic exec_instr(input logic [3:0] ic, input logic cnd,
      input logic [63:0] vc, input logic [63:0] vp, input logic [63:0] vm,
      input int waits, input int ferr, input bit merr, output string tr);
    int mcnt;
    int n;
    string c;
    mcnt = 0;
    tr = "";
    icode = ic; cond = cnd; valC = vc; valP = vp; valM = vm;
    ifun = 4'($urandom);
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cyc > 0 && f_en) return;
      if (halted) begin
        tr = {tr, "H"};
        instruct_err = 1'b0; mem_err = 1'b0;
        return;
      end
      start = 1'($urandom_range(0, 1));
      instruct_err = f_en && (ferr == 1);
      mem_err = (f_en && ferr == 2) || (m_en && merr);
      if (m_en) begin
        mcnt++;
        mem_ready = (mcnt > waits);
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      n = int'(f_en) + int'(d_en) + int'(e_en) + int'(m_en) + int'(w_en);
      if (n > 1)      c = "#";
      else if (f_en)  c = "f";
      else if (d_en)  c = "d";
      else if (e_en)  c = "e";
      else if (m_en)  c = "m";
      else if (w_en)  c = "w";
      else if (busy)  c = "-";
      else            c = "i";
      if (cc_we) c = (c == "e") ? "E" : "?";
      tr = {tr, c};
      step();
    end
    tr = {tr, "T"};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    step(); step();
    checks++;
    if ({f_en, d_en, e_en, m_en, w_en, cc_we, busy, halted} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 00000000",
               {f_en, d_en, e_en, m_en, w_en, cc_we, busy, halted});
    end
    checks++;
    if (PC !== RST_PC) begin errors++; $display("FAIL reset_pc got %h exp %h", PC, RST_PC); end
    checks++;
    if (stat !== AOK) begin errors++; $display("FAIL reset_stat got %0d exp %0d", stat, AOK); end
`ifdef PERF_CNT_EN
    checks++;
    if (cycle_cnt !== 0 || inst_cnt !== 0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", cycle_cnt, inst_cnt);
    end
`endif
    rst = 1'b0; start = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_hold got busy %b exp 0", busy); end
    do_start();
    checks++;
    if (f_en !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL start_fetch got f_en %b busy %b exp 1 1", f_en, busy);
    end
  endtask

  task automatic test_opq();
    string tr;
    do_reset(); do_start();
    exec_instr(4'h6, 1'b0, 64'h55, 64'd2, 64'h66, 0, 0, 1'b0, tr);
    checks++;
    if (tr != "fdEmw-") begin errors++; $display("FAIL opq_trace got %s exp fdEmw-", tr); end
    checks++;
    if (PC !== 64'd2) begin errors++; $display("FAIL opq_pc got %h exp 2", PC); end
    checks++;
    if (stat !== AOK) begin errors++; $display("FAIL opq_stat got %0d exp %0d", stat, AOK); end
  endtask

  task automatic test_jxx();
    string tr;
    exec_instr(4'h7, 1'b1, 64'd3, 64'd9, 64'h11, 0, 0, 1'b0, tr);
    checks++;
    if (tr != "fdemw-" || PC !== 64'd3) begin
      errors++; $display("FAIL jxx_taken got %s pc %h exp fdemw- pc 3", tr, PC);
    end
    exec_instr(4'h7, 1'b0, 64'd3, 64'd9, 64'h11, 0, 0, 1'b0, tr);
    checks++;
    if (tr != "fdemw-" || PC !== 64'd9) begin
      errors++; $display("FAIL jxx_not_taken got %s pc %h exp fdemw- pc 9", tr, PC);
    end
  endtask

  task automatic test_mem_wait();
    string tr;
    exec_instr(4'hA, 1'b0, 64'h1, 64'h24, 64'h2, 3, 0, 1'b0, tr);
    checks++;
    if (tr != "fdemmmmw-") begin errors++; $display("FAIL mem_wait_trace got %s exp fdemmmmw-", tr); end
    checks++;
    if (PC !== 64'h24) begin errors++; $display("FAIL mem_wait_pc got %h exp 24", PC); end
  endtask

  task automatic test_ret_halt();
    string tr;
    exec_instr(4'h9, 1'b1, 64'h7, 64'h8, 64'h40, 1, 0, 1'b0, tr);
    checks++;
    if (tr != "fdemmw-" || PC !== 64'h40) begin
      errors++; $display("FAIL ret got %s pc %h exp fdemmw- pc 40", tr, PC);
    end
    exec_instr(4'h0, 1'b0, 64'h7, 64'h8, 64'h9, 0, 0, 1'b0, tr);
    checks++;
    if (tr != "fH" || stat !== HLT || halted !== 1'b1) begin
      errors++; $display("FAIL halt got %s stat %0d halted %b exp fH 2 1", tr, stat, halted);
    end
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    checks++;
    if (PC !== 64'h40 || stat !== HLT || halted !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL halt_hold got pc %h stat %0d halted %b busy %b exp 40 2 1 0", PC, stat, halted, busy);
    end
  endtask

  task automatic test_errors();
    string tr;
    do_reset();
    checks++;
    if (stat !== AOK || halted !== 1'b0) begin
      errors++; $display("FAIL halt_reset got stat %0d halted %b exp 1 0", stat, halted);
    end
    do_start();
    exec_instr(4'h3, 1'b0, 64'h1, 64'h2, 64'h3, 0, 1, 1'b0, tr);
    checks++;
    if (tr != "fH" || stat !== INS) begin errors++; $display("FAIL ins_err got %s stat %0d exp fH 4", tr, stat); end
    do_reset(); do_start();
    exec_instr(4'hC, 1'b0, 64'h1, 64'h2, 64'h3, 0, 0, 1'b0, tr);
    checks++;
    if (tr != "fH" || stat !== INS) begin errors++; $display("FAIL bad_icode got %s stat %0d exp fH 4", tr, stat); end
    do_reset(); do_start();
    exec_instr(4'h2, 1'b0, 64'h1, 64'h2, 64'h3, 0, 2, 1'b0, tr);
    checks++;
    if (tr != "fH" || stat !== ADR) begin errors++; $display("FAIL fetch_adr got %s stat %0d exp fH 3", tr, stat); end
    do_reset(); do_start();
    exec_instr(4'h4, 1'b0, 64'h1, 64'h2, 64'h3, 2, 0, 1'b1, tr);
    checks++;
    if (tr != "fdemH" || stat !== ADR || PC !== RST_PC) begin
      errors++; $display("FAIL mem_adr got %s stat %0d pc %h exp fdemH 3 %h", tr, stat, PC, RST_PC);
    end
  endtask

  task automatic test_timeout();
    string tr;
    string et;
    do_reset(); do_start();
    exec_instr(4'h5, 1'b0, 64'h1, 64'h88, 64'h3, MEM_TO - 1, 0, 1'b0, tr);
    et = m_trace(4'h5, MEM_TO - 1, 0, 1'b0);
    checks++;
    if (tr != et || PC !== 64'h88) begin
      errors++; $display("FAIL wait_max got %s pc %h exp %s pc 88", tr, PC, et);
    end
    exec_instr(4'h8, 1'b0, 64'h1, 64'h99, 64'h3, MEM_TO, 0, 1'b0, tr);
    et = m_trace(4'h8, MEM_TO, 0, 1'b0);
    checks++;
    if (tr != et || stat !== ADR || PC !== 64'h88) begin
      errors++; $display("FAIL timeout got %s stat %0d pc %h exp %s 3 88", tr, stat, PC, et);
    end
  endtask

  task automatic test_reset_mid();
    string tr;
    do_reset(); do_start();
    exec_instr(4'h1, 1'b0, 64'h1, 64'h77, 64'h3, 0, 0, 1'b0, tr);
    icode = 4'h4; instruct_err = 1'b0; mem_err = 1'b0; mem_ready = 1'b0;
    for (int k = 0; k < 10 && !m_en; k++) step();
    step();
    checks++;
    if (m_en !== 1'b1 || PC !== 64'h77) begin
      errors++; $display("FAIL mid_setup got m_en %b pc %h exp 1 77", m_en, PC);
    end
    rst = 1'b1; start = 1'b1; mem_ready = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    checks++;
    if ({f_en, d_en, e_en, m_en, w_en, cc_we, busy, halted} !== 8'b0 ||
        PC !== RST_PC || stat !== AOK) begin
      errors++;
      $display("FAIL mid_reset got strobes %b pc %h stat %0d exp 00000000 %h 1",
               {f_en, d_en, e_en, m_en, w_en, cc_we, busy, halted}, PC, RST_PC, stat);
    end
`ifdef PERF_CNT_EN
    checks++;
    if (cycle_cnt !== 0 || inst_cnt !== 0) begin
      errors++; $display("FAIL mid_reset_cnt got %0d/%0d exp 0/0", cycle_cnt, inst_cnt);
    end
`endif
  endtask

  task automatic test_random();
    string tr, et;
    logic [3:0]  ic;
    logic        cnd;
    logic [63:0] vc, vp, vm, pc_m, pc_exp;
    logic [2:0]  st_exp;
    int r, waits, ferr, cyc_m, inst_m;
    bit merr;
    do_reset(); do_start();
    pc_m = RST_PC; cyc_m = 0; inst_m = 0;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4)      ic = 4'h0;
      else if (r < 8) ic = 4'($urandom_range(12, 15));
      else            ic = 4'($urandom_range(1, 11));
      cnd = 1'($urandom_range(0, 1));
      vc = {$urandom, $urandom}; vp = {$urandom, $urandom}; vm = {$urandom, $urandom};
      r = $urandom_range(0, 99);
      ferr = (r < 5) ? 1 : (r < 8) ? 2 : 0;
      merr = ($urandom_range(0, 99) < 4);
      waits = ($urandom_range(0, 9) == 0) ? MEM_TO : $urandom_range(0, 4);
      exec_instr(ic, cnd, vc, vp, vm, waits, ferr, merr, tr);
      et = m_trace(ic, waits, ferr, merr);
      st_exp = m_stat(ic, waits, ferr, merr);
      pc_exp = (st_exp == AOK) ? m_next_pc(ic, cnd, vc, vp, vm) : pc_m;
      checks++;
      if (tr != et) begin errors++; $display("FAIL rnd_trace_%0d ic %h got %s exp %s", n, ic, tr, et); end
      checks++;
      if (PC !== pc_exp || stat !== st_exp) begin
        errors++;
        $display("FAIL rnd_state_%0d got pc %h stat %0d exp pc %h stat %0d", n, PC, stat, pc_exp, st_exp);
      end
      cyc_m += (st_exp == AOK) ? et.len() : et.len() - 1;
      if (st_exp == AOK) inst_m++;
`ifdef PERF_CNT_EN
      checks++;
      if (cycle_cnt !== 32'(cyc_m) || inst_cnt !== 32'(inst_m)) begin
        errors++;
        $display("FAIL rnd_cnt_%0d got %0d/%0d exp %0d/%0d", n, cycle_cnt, inst_cnt, cyc_m, inst_m);
      end
`endif
      pc_m = pc_exp;
      if (st_exp != AOK) begin
        do_reset(); do_start();
        pc_m = RST_PC; cyc_m = 0; inst_m = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_opq();
    test_jxx();
    test_mem_wait();
    test_ret_halt();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
